qa_drv_hc_traffic_gen: RTL and testbench

QA_DRV_HC_TRAFFIC_GEN -- requirements
Module: qa_drv_hc_traffic_gen

---
 rtl/qa_drv_hc_pkg.sv | 30 +++
 rtl/qa_drv_hc_traffic_stats.sv | 50 +++++
 rtl/qa_drv_hc_traffic_gen.sv | 162 ++++++++++++++++
 tb/tb_qa_drv_hc_traffic_gen.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qa_drv_hc_pkg.sv
// rtl/qa_drv_hc_pkg.sv - shared modes, encodings and status types for the traffic generator
package qa_drv_hc_pkg;

   localparam logic [2:0] MODE_NORMAL   = 3'd0;
   localparam logic [2:0] MODE_SINK     = 3'd1;
   localparam logic [2:0] MODE_SOURCE   = 3'd2;
   localparam logic [2:0] MODE_LOOPBACK = 3'd3;
   localparam logic [2:0] MODE_CHECK    = 3'd4;

   // State values match the command encoding so a legal cmd_mode loads directly.
   typedef enum logic [2:0] {
      ST_NORMAL   = 3'd0,
      ST_SINK     = 3'd1,
      ST_SOURCE   = 3'd2,
      ST_LOOPBACK = 3'd3,
      ST_CHECK    = 3'd4
   } mode_e;

   // Fixed-width status counters; the message count is sized per instance.
   typedef struct packed {
      logic [31:0] cycles;
      logic [15:0] errors;
   } stat_t;

   // Codes above CHECK are reserved and leave the block untouched.
   function automatic logic mode_legal(input logic [2:0] m);
      return m <= MODE_CHECK;
   endfunction

endpackage

// File: rtl/qa_drv_hc_traffic_stats.sv
// rtl/qa_drv_hc_traffic_stats.sv - cycle, message and error counters for one test run
module qa_drv_hc_traffic_stats
   import qa_drv_hc_pkg::*;
#(
   parameter int COUNT_WIDTH = 31
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear_i,
   input  logic                   cycle_en_i,
   input  logic                   msg_en_i,
   input  logic                   err_en_i,
   output logic [31:0]            cycles_o,
   output logic [COUNT_WIDTH-1:0] msgs_o,
   output logic [15:0]            errors_o
);

   stat_t                  cnt_q, cnt_d;
   logic [COUNT_WIDTH-1:0] msgs_q, msgs_d;

   // A new command wipes the counters; otherwise cycles and errors saturate, messages wrap.
   always_comb begin
      cnt_d  = cnt_q;
      msgs_d = msgs_q;
      if (clear_i) begin
         cnt_d  = '0;
         msgs_d = '0;
      end else begin
         if (cycle_en_i && (cnt_q.cycles != '1)) cnt_d.cycles = cnt_q.cycles + 32'd1;
         if (err_en_i && (cnt_q.errors != '1))   cnt_d.errors = cnt_q.errors + 16'd1;
         if (msg_en_i)                           msgs_d = msgs_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         msgs_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         msgs_q <= msgs_d;
      end
   end

   assign cycles_o = cnt_q.cycles;
   assign errors_o = cnt_q.errors;
   assign msgs_o   = msgs_q;

endmodule

// File: rtl/qa_drv_hc_traffic_gen.sv
// rtl/qa_drv_hc_traffic_gen.sv - host-channel traffic generator with sink, source, loopback and check modes
module qa_drv_hc_traffic_gen
   import qa_drv_hc_pkg::*;
#(
   parameter int DATA_WIDTH  = 512,
   parameter int COUNT_WIDTH = 31
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   input  logic [2:0]             cmd_mode,
   input  logic [COUNT_WIDTH-1:0] cmd_count,
   input  logic                   en_user_channel,
   output logic [DATA_WIDTH-1:0]  rx_fifo_data,
   output logic                   rx_fifo_rdy,
   input  logic                   rx_fifo_enable,
   input  logic [DATA_WIDTH-1:0]  tx_fifo_data,
   output logic                   tx_fifo_rdy,
   input  logic                   tx_fifo_enable,
   input  logic [DATA_WIDTH-1:0]  rx_data,
   input  logic                   rx_rdy,
   output logic                   rx_enable,
   output logic [DATA_WIDTH-1:0]  tx_data,
   input  logic                   tx_rdy,
   output logic                   tx_enable,
   output logic                   stat_active,
   output logic                   stat_done,
   output logic [31:0]            stat_cycles,
   output logic [COUNT_WIDTH-1:0] stat_msgs,
   output logic [15:0]            stat_errors
);

   localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   mode_e                  state_q, state_d;
   logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
   logic [COUNT_WIDTH-1:0] seq_q, seq_d;
   logic                   done_q, done_d;
   logic                   cmd_accept, complete, msg_en, err_en;
   logic [COUNT_WIDTH-1:0] rx_seq;
   logic [15:0]            err_next;

   assign cmd_accept = cmd_valid && mode_legal(cmd_mode);
   assign rx_seq     = rx_data[COUNT_WIDTH:1];
   assign err_next   = (stat_errors == 16'hFFFF) ? stat_errors : stat_errors + 16'd1;

   // Per-mode channel steering, completion detection and next-state selection.
   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      seq_d        = seq_q;
      done_d       = 1'b0;
      complete     = 1'b0;
      msg_en       = 1'b0;
      err_en       = 1'b0;
      rx_fifo_data = rx_data;
      rx_fifo_rdy  = 1'b0;
      tx_fifo_rdy  = 1'b0;
      rx_enable    = 1'b0;
      tx_enable    = 1'b0;
      tx_data      = '0;
      case (state_q)
         ST_NORMAL: begin
            rx_fifo_rdy = rx_rdy;
            rx_enable   = rx_fifo_enable;
            tx_fifo_rdy = tx_rdy && en_user_channel;
            tx_enable   = tx_fifo_enable;
            tx_data     = tx_fifo_data;
         end
         ST_SINK: begin
            rx_enable = rx_rdy && tx_rdy;
            msg_en    = rx_enable;
            if (rx_enable && rx_data[0]) begin
               complete  = 1'b1;
               tx_enable = 1'b1;
               tx_data   = rx_data;
            end
         end
         ST_SOURCE: begin
            rx_enable = rx_rdy;
            // A zero count has nothing to send and finishes on its first cycle.
            if (remaining_q == '0) begin
               complete = 1'b1;
            end else begin
               tx_enable                = tx_rdy;
               tx_data[COUNT_WIDTH:0]   = {remaining_q, remaining_q == CNT_ONE};
               msg_en                   = tx_rdy;
               if (tx_rdy) begin
                  remaining_d = remaining_q - CNT_ONE;
                  complete    = (remaining_q == CNT_ONE);
               end
            end
         end
         ST_LOOPBACK: begin
            rx_enable = rx_rdy && tx_rdy;
            tx_enable = rx_enable;
            tx_data   = rx_data;
            msg_en    = rx_enable;
            complete  = rx_enable && rx_data[0];
         end
         ST_CHECK: begin
            rx_enable = rx_rdy && tx_rdy;
            msg_en    = rx_enable;
            if (rx_enable) begin
               // On a match received+1 equals expected+1, so one update covers both the step and the resync.
               seq_d  = rx_seq + CNT_ONE;
               err_en = (rx_seq != seq_q);
               if (rx_data[0]) begin
                  complete      = 1'b1;
                  tx_enable     = 1'b1;
                  tx_data[15:0] = err_en ? err_next : stat_errors;
               end
            end
         end
         default: state_d = ST_NORMAL;
      endcase
      if (complete) begin
         state_d = ST_NORMAL;
         done_d  = 1'b1;
      end
      // A command overrides a same-cycle completion and suppresses its done pulse.
      if (cmd_accept) begin
         state_d     = mode_e'(cmd_mode);
         remaining_d = cmd_count;
         seq_d       = '0;
         done_d      = 1'b0;
      end
   end

   // Mode, source countdown, expected sequence and done pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_NORMAL;
         remaining_q <= '0;
         seq_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         seq_q       <= seq_d;
         done_q      <= done_d;
      end
   end

   assign stat_active = (state_q != ST_NORMAL);
   assign stat_done   = done_q;

   qa_drv_hc_traffic_stats #(
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_stats (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (cmd_accept),
      .cycle_en_i (stat_active),
      .msg_en_i   (msg_en),
      .err_en_i   (err_en),
      .cycles_o   (stat_cycles),
      .msgs_o     (stat_msgs),
      .errors_o   (stat_errors)
   );

endmodule

// File: tb/tb_qa_drv_hc_traffic_gen.sv
// tb/tb_qa_drv_hc_traffic_gen.sv - directed scoreboard bench for the traffic generator
module tb_qa_drv_hc_traffic_gen;

   localparam int DW = 512;
   localparam int CW = 31;

   logic          clk;
   logic          reset;
   logic          cmd_valid;
   logic [2:0]    cmd_mode;
   logic [CW-1:0] cmd_count;
   logic          en_user_channel;
   logic [DW-1:0] rx_fifo_data;
   logic          rx_fifo_rdy;
   logic          rx_fifo_enable;
   logic [DW-1:0] tx_fifo_data;
   logic          tx_fifo_rdy;
   logic          tx_fifo_enable;
   logic [DW-1:0] rx_data;
   logic          rx_rdy;
   logic          rx_enable;
   logic [DW-1:0] tx_data;
   logic          tx_rdy;
   logic          tx_enable;
   logic          stat_active;
   logic          stat_done;
   logic [31:0]   stat_cycles;
   logic [CW-1:0] stat_msgs;
   logic [15:0]   stat_errors;

   int            total;
   int            bad;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_w;

   qa_drv_hc_traffic_gen #(
      .DATA_WIDTH  (DW),
      .COUNT_WIDTH (CW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .cmd_valid       (cmd_valid),
      .cmd_mode        (cmd_mode),
      .cmd_count       (cmd_count),
      .en_user_channel (en_user_channel),
      .rx_fifo_data    (rx_fifo_data),
      .rx_fifo_rdy     (rx_fifo_rdy),
      .rx_fifo_enable  (rx_fifo_enable),
      .tx_fifo_data    (tx_fifo_data),
      .tx_fifo_rdy     (tx_fifo_rdy),
      .tx_fifo_enable  (tx_fifo_enable),
      .rx_data         (rx_data),
      .rx_rdy          (rx_rdy),
      .rx_enable       (rx_enable),
      .tx_data         (tx_data),
      .tx_rdy          (tx_rdy),
      .tx_enable       (tx_enable),
      .stat_active     (stat_active),
      .stat_done       (stat_done),
      .stat_cycles     (stat_cycles),
      .stat_msgs       (stat_msgs),
      .stat_errors     (stat_errors)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic send_cmd(input logic [2:0] mode, input logic [CW-1:0] cnt);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_mode = mode; cmd_count = cnt;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_mode = 3'd0; cmd_count = '0;
   endtask

   task automatic test_reset();
      logic [DW-1:0] pa, pb;
      pa = {16{32'h1234_5678}};
      pb = {16{32'h9ABC_DEF0}};
      reset = 1'b1; cmd_valid = 0; cmd_mode = 0; cmd_count = 0;
      en_user_channel = 0; rx_fifo_enable = 0; tx_fifo_data = '0; tx_fifo_enable = 0;
      rx_data = '0; rx_rdy = 0; tx_rdy = 0;
      #2;
      total++; if (stat_active !== 1'b0) begin bad++; $display("FAIL rst_active got=%b exp=0", stat_active); end
      total++; if (stat_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", stat_done); end
      total++; if (stat_cycles !== 32'd0 || stat_msgs !== '0 || stat_errors !== 16'd0) begin
         bad++; $display("FAIL rst_counters got=%0d/%0d/%0d exp=0/0/0", stat_cycles, stat_msgs, stat_errors);
      end
      rx_rdy = 1; rx_data = pa; rx_fifo_enable = 1; tx_rdy = 1; en_user_channel = 1;
      tx_fifo_enable = 1; tx_fifo_data = pb;
      #1;
      total++; if (rx_fifo_rdy !== 1'b1 || rx_enable !== 1'b1 || rx_fifo_data !== pa) begin
         bad++; $display("FAIL normal_rx got=%b/%b/%0h exp=1/1/%0h", rx_fifo_rdy, rx_enable, rx_fifo_data, pa);
      end
      total++; if (tx_fifo_rdy !== 1'b1 || tx_enable !== 1'b1 || tx_data !== pb) begin
         bad++; $display("FAIL normal_tx got=%b/%b/%0h exp=1/1/%0h", tx_fifo_rdy, tx_enable, tx_data, pb);
      end
      en_user_channel = 0;
      #1;
      total++; if (tx_fifo_rdy !== 1'b0) begin bad++; $display("FAIL normal_user_gate got=%b exp=0", tx_fifo_rdy); end
      rx_rdy = 0; rx_data = '0; rx_fifo_enable = 0; tx_rdy = 0; tx_fifo_enable = 0; tx_fifo_data = '0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_source3();
      int sent;
      logic [DW-1:0] w;
      sent = 0;
      exp_q.delete();
      for (int r = 3; r >= 1; r--) begin
         w = '0;
         w[CW:1] = CW'(r);
         w[0] = (r == 1);
         exp_q.push_back(w);
      end
      tx_rdy = 1;
      send_cmd(3'd2, CW'(3));
      for (int c = 0; c < 10 && sent < 3; c++) begin
         @(negedge clk);
         if (tx_enable === 1'b1) begin
            exp_w = exp_q.pop_front();
            total++; if (tx_data !== exp_w) begin bad++; $display("FAIL src_word%0d got=%0h exp=%0h", sent, tx_data, exp_w); end
            sent++;
         end
      end
      total++; if (sent != 3) begin bad++; $display("FAIL src_count got=%0d exp=3", sent); end
      @(negedge clk);
      total++; if (stat_done !== 1'b1 || stat_active !== 1'b0) begin
         bad++; $display("FAIL src_done got=%b/%b exp=1/0", stat_done, stat_active);
      end
      total++; if (stat_msgs !== CW'(3) || stat_cycles !== 32'd3) begin
         bad++; $display("FAIL src_stats got=%0d/%0d exp=3/3", stat_msgs, stat_cycles);
      end
      @(negedge clk);
      total++; if (stat_done !== 1'b0) begin bad++; $display("FAIL src_done_pulse got=%b exp=0", stat_done); end
      tx_rdy = 0;
   endtask

   task automatic test_loopback();
      logic [DW-1:0] words [3];
      int idx;
      logic tog;
      for (int i = 0; i < 3; i++) begin
         words[i] = '0;
         words[i][DW-1:DW-32] = 32'hC0DE_0000 + 32'(i);
      end
      words[0][7:0] = 8'h10; words[1][7:0] = 8'h20; words[2][7:0] = 8'h31;
      exp_q.delete();
      for (int i = 0; i < 3; i++) exp_q.push_back(words[i]);
      send_cmd(3'd3, '0);
      idx = 0; tog = 0;
      for (int c = 0; c < 20 && idx < 3; c++) begin
         @(posedge clk); #1;
         tx_rdy = tog; rx_rdy = 1; rx_data = words[idx]; tog = ~tog;
         @(negedge clk);
         if (tx_rdy == 1'b0) begin
            total++; if (rx_enable !== 1'b0 || tx_enable !== 1'b0) begin
               bad++; $display("FAIL lb_stall got=%b/%b exp=0/0", rx_enable, tx_enable);
            end
         end else begin
            exp_w = exp_q.pop_front();
            total++; if (rx_enable !== 1'b1 || tx_enable !== 1'b1 || tx_data !== exp_w) begin
               bad++; $display("FAIL lb_word%0d got=%b/%b/%0h exp=1/1/%0h", idx, rx_enable, tx_enable, tx_data, exp_w);
            end
            idx++;
         end
      end
      total++; if (idx != 3) begin bad++; $display("FAIL lb_count got=%0d exp=3", idx); end
      @(posedge clk); #1;
      rx_rdy = 0; tx_rdy = 0; rx_data = '0;
      @(negedge clk);
      total++; if (stat_active !== 1'b0 || stat_done !== 1'b1 || stat_msgs !== CW'(3)) begin
         bad++; $display("FAIL lb_end got=%b/%b/%0d exp=0/1/3", stat_active, stat_done, stat_msgs);
      end
   endtask

   task automatic test_check();
      int seqs [5];
      logic [DW-1:0] w;
      logic [CW-1:0] expect_seq;
      int err;
      seqs = '{0, 1, 5, 6, 7};
      expect_seq = '0; err = 0;
      for (int i = 0; i < 5; i++) begin
         if (CW'(seqs[i]) != expect_seq) err++;
         expect_seq = CW'(seqs[i]) + CW'(1);
      end
      exp_q.delete();
      w = '0; w[15:0] = 16'(err);
      exp_q.push_back(w);
      send_cmd(3'd4, '0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         w = '0; w[CW:1] = CW'(seqs[i]); w[0] = (i == 4);
         rx_data = w; rx_rdy = 1; tx_rdy = 1;
         @(negedge clk);
         if (i < 4) begin
            total++; if (rx_enable !== 1'b1 || tx_enable !== 1'b0) begin
               bad++; $display("FAIL chk_msg%0d got=%b/%b exp=1/0", i, rx_enable, tx_enable);
            end
         end else begin
            exp_w = exp_q.pop_front();
            total++; if (tx_enable !== 1'b1 || tx_data !== exp_w) begin
               bad++; $display("FAIL chk_final got=%b/%0h exp=1/%0h", tx_enable, tx_data, exp_w);
            end
         end
      end
      @(posedge clk); #1;
      rx_rdy = 0; tx_rdy = 0; rx_data = '0;
      @(negedge clk);
      total++; if (stat_errors !== 16'(err) || stat_done !== 1'b1 || stat_msgs !== CW'(5)) begin
         bad++; $display("FAIL chk_stats got=%0d/%b/%0d exp=%0d/1/5", stat_errors, stat_done, stat_msgs, err);
      end
   endtask

   task automatic test_illegal_mode();
      send_cmd(3'd5, CW'(7));
      @(negedge clk);
      total++; if (stat_active !== 1'b0 || stat_msgs !== CW'(5) || stat_errors !== 16'd1) begin
         bad++; $display("FAIL illegal_hold got=%b/%0d/%0d exp=0/5/1", stat_active, stat_msgs, stat_errors);
      end
   endtask

   task automatic test_source_zero();
      tx_rdy = 1;
      send_cmd(3'd2, '0);
      @(negedge clk);
      total++; if (tx_enable !== 1'b0 || stat_active !== 1'b1) begin
         bad++; $display("FAIL src0_entry got=%b/%b exp=0/1", tx_enable, stat_active);
      end
      @(negedge clk);
      total++; if (stat_done !== 1'b1 || stat_msgs !== '0 || stat_active !== 1'b0) begin
         bad++; $display("FAIL src0_done got=%b/%0d/%b exp=1/0/0", stat_done, stat_msgs, stat_active);
      end
      total++; if (stat_cycles !== 32'd1 || exp_q.size() != 0) begin
         bad++; $display("FAIL src0_cycles got=%0d/%0d exp=1/0", stat_cycles, exp_q.size());
      end
      tx_rdy = 0;
   endtask

   task automatic test_abort();
      logic saw_done;
      send_cmd(3'd1, '0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         rx_rdy = 1; tx_rdy = 1; rx_data = '0; rx_data[8:1] = 8'(i + 2);
         @(negedge clk);
         total++; if (rx_enable !== 1'b1 || tx_enable !== 1'b0) begin
            bad++; $display("FAIL sink_msg%0d got=%b/%b exp=1/0", i, rx_enable, tx_enable);
         end
      end
      @(posedge clk); #1;
      cmd_valid = 1; cmd_mode = 3'd0;
      @(posedge clk); #1;
      cmd_valid = 0; rx_rdy = 0; tx_rdy = 0; rx_data = '0;
      @(negedge clk);
      total++; if (stat_active !== 1'b0 || stat_done !== 1'b0 || stat_msgs !== '0) begin
         bad++; $display("FAIL abort_state got=%b/%b/%0d exp=0/0/0", stat_active, stat_done, stat_msgs);
      end
      saw_done = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (stat_done === 1'b1) saw_done = 1;
      end
      total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", saw_done); end
   endtask

   task automatic test_reset_mid();
      int sent;
      sent = 0;
      tx_rdy = 1;
      send_cmd(3'd2, CW'(100));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (tx_enable === 1'b1) sent++;
      end
      total++; if (sent != 3) begin bad++; $display("FAIL rmid_running got=%0d exp=3", sent); end
      reset = 1'b1;
      #1;
      total++; if (stat_active !== 1'b0 || stat_done !== 1'b0 || tx_enable !== 1'b0 || tx_data !== '0) begin
         bad++; $display("FAIL rmid_outputs got=%b/%b/%b/%0h exp=0/0/0/0", stat_active, stat_done, tx_enable, tx_data);
      end
      total++; if (stat_cycles !== 32'd0 || stat_msgs !== '0 || stat_errors !== 16'd0 || tx_fifo_rdy !== 1'b0) begin
         bad++; $display("FAIL rmid_counters got=%0d/%0d/%0d/%b exp=0/0/0/0", stat_cycles, stat_msgs, stat_errors, tx_fifo_rdy);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      tx_rdy = 0;
      @(negedge clk);
      total++; if (stat_done !== 1'b0 || stat_active !== 1'b0) begin
         bad++; $display("FAIL rmid_after got=%b/%b exp=0/0", stat_done, stat_active);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_source3();
      test_loopback();
      test_check();
      test_illegal_mode();
      test_source_zero();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
